// File: rtl/spdif_subframe_decoder.sv
`timescale 1ns/1ps
// S/PDIF subframe decoder: oversamples the biphase-mark line, learns the
// unit interval T, classifies pulses as 1T/2T/3T and assembles preamble +
// 28 data slots into audio, V/U/C and parity/frame error flags.
module spdif_subframe_decoder #(
  parameter int CNT_W  = 8,
  parameter int DATA_W = 24,
  parameter int WIN    = 64,
  parameter int MIN_T  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SPDIFin,
  output logic              clkout,
  output logic [DATA_W-1:0] Dout,
  output logic [1:0]        synccode,
  output logic [2:0]        vuc,
  output logic              parity_err,
  output logic              frame_err,
  output logic              locked
);

  localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Pulse classes; 0 doubles as "illegal width"
  localparam logic [1:0] C_BAD = 2'd0;
  localparam logic [1:0] C_1T  = 2'd1;
  localparam logic [1:0] C_2T  = 2'd2;
  localparam logic [1:0] C_3T  = 2'd3;

  typedef enum logic [1:0] {HUNT, PRE, DATA, HALF} state_t;

  logic             sync1_reg, sync2_reg, sync3_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_inc, w_reg;
  logic             edge_reg;
  logic             sat;
  logic [CNT_W-1:0] rmin_reg, t_unit_reg, wmin;
  logic [WIN_W-1:0] ecnt_reg;
  logic [CNT_W+1:0] t_ext, half, th1, th2, th3, w_ext;
  logic [1:0]       class_next, pclass_reg;
  logic             pv_reg;

  state_t           state_reg;
  logic [1:0]       pidx_reg;
  logic [5:0]       pseq_reg, pseq_next;
  logic [1:0]       pre_code, sync_cur_reg;
  logic [4:0]       slot_reg;
  logic [27:0]      shreg, frame_next;

  assign cnt_inc = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;
  assign sat     = (cnt_reg == CNT_MAX);
  assign wmin    = (w_reg < rmin_reg) ? w_reg : rmin_reg;

  // Synchronise the line, detect transitions and measure pulse widths
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      edge_reg  <= 1'b0;
      cnt_reg   <= '0;
      w_reg     <= '0;
    end else begin
      sync1_reg <= SPDIFin;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      edge_reg  <= sync2_reg ^ sync3_reg;
      if (sync2_reg ^ sync3_reg) begin
        w_reg   <= cnt_inc;
        cnt_reg <= '0;
      end else begin
        cnt_reg <= cnt_inc;
      end
    end
  end

  // Learn T as the shortest pulse of each window; a dead line drops lock
  always_ff @(posedge clk) begin
    if (rst) begin
      rmin_reg   <= CNT_MAX;
      t_unit_reg <= CNT_MAX;
      ecnt_reg   <= '0;
      locked     <= 1'b0;
    end else begin
      if (edge_reg) begin
        ecnt_reg <= ecnt_reg + 1'b1;
        if (ecnt_reg == WIN_W'(WIN - 1)) begin
          t_unit_reg <= wmin;
          locked     <= (wmin >= CNT_W'(MIN_T));
          rmin_reg   <= CNT_MAX;
        end else begin
          rmin_reg <= wmin;
        end
      end
      // Saturation overrides a coincident window end
      if (sat) begin
        locked     <= 1'b0;
        t_unit_reg <= CNT_MAX;
      end
    end
  end

  // Thresholds sit half a T above each nominal width; ties go to the longer class
  always_comb begin
    t_ext      = {2'b00, t_unit_reg};
    half       = t_ext >> 1;
    th1        = t_ext + half;
    th2        = th1 + t_ext;
    th3        = th2 + t_ext;
    w_ext      = {2'b00, w_reg};
    class_next = C_BAD;
    if (w_ext < th1)      class_next = C_1T;
    else if (w_ext < th2) class_next = C_2T;
    else if (w_ext < th3) class_next = C_3T;
  end

  // Register the classified pulse for the frame FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      pv_reg     <= 1'b0;
      pclass_reg <= C_BAD;
    end else begin
      pv_reg     <= edge_reg;
      pclass_reg <= class_next;
    end
  end

  // Preamble match on the three pulses following the leading 3T
  always_comb begin
    pseq_next  = {pseq_reg[3:0], pclass_reg};
    frame_next = {state_reg == HALF, shreg[27:1]};
    case (pseq_next)
      {C_1T, C_1T, C_3T}: pre_code = 2'b01;
      {C_3T, C_1T, C_1T}: pre_code = 2'b10;
      {C_2T, C_1T, C_2T}: pre_code = 2'b11;
      default:            pre_code = 2'b00;
    endcase
  end

  // Frame FSM: preamble tracking, slot assembly and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= HUNT;
      pidx_reg     <= 2'd0;
      pseq_reg     <= '0;
      sync_cur_reg <= 2'b00;
      slot_reg     <= 5'd0;
      shreg        <= '0;
      clkout       <= 1'b0;
      frame_err    <= 1'b0;
      Dout         <= '0;
      synccode     <= 2'b00;
      vuc          <= 3'b000;
      parity_err   <= 1'b0;
    end else begin
      clkout    <= 1'b0;
      frame_err <= 1'b0;
      if (!locked) begin
        state_reg <= HUNT;
      end else if (pv_reg) begin
        case (state_reg)
          HUNT: begin
            if (pclass_reg == C_3T) begin
              state_reg <= PRE;
              pidx_reg  <= 2'd1;
            end
          end
          PRE: begin
            if (pidx_reg == 2'd0) begin
              // Leading 3T of a preamble that directly follows slot 31
              if (pclass_reg == C_3T) begin
                pidx_reg <= 2'd1;
              end else begin
                frame_err <= 1'b1;
                state_reg <= HUNT;
              end
            end else begin
              pseq_reg <= pseq_next;
              if (pidx_reg == 2'd3) begin
                if (pre_code != 2'b00) begin
                  sync_cur_reg <= pre_code;
                  slot_reg     <= 5'd4;
                  state_reg    <= DATA;
                end else begin
                  frame_err <= 1'b1;
                  state_reg <= HUNT;
                end
              end else begin
                pidx_reg <= pidx_reg + 2'd1;
              end
            end
          end
          DATA, HALF: begin
            if (state_reg == DATA && pclass_reg == C_1T) begin
              state_reg <= HALF;
            end else if ((state_reg == DATA && pclass_reg == C_2T) ||
                         (state_reg == HALF && pclass_reg == C_1T)) begin
              shreg <= frame_next;
              if (slot_reg == 5'd31) begin
                clkout     <= 1'b1;
                Dout       <= frame_next[23 -: DATA_W];
                synccode   <= sync_cur_reg;
                vuc        <= {frame_next[24], frame_next[25], frame_next[26]};
                parity_err <= ^frame_next;
                state_reg  <= PRE;
                pidx_reg   <= 2'd0;
              end else begin
                slot_reg  <= slot_reg + 5'd1;
                state_reg <= DATA;
              end
            end else begin
              frame_err <= 1'b1;
              state_reg <= HUNT;
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

endmodule
